// File: rtl/inter_rr_sched.sv
// inter_rr_sched: round-robin scheduler issuing packets from three master FIFOs onto a shared two-slave bus
module inter_rr_sched #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_1,
  input  logic       in_valid_2,
  input  logic       in_valid_3,
  input  logic [6:0] data_in_1,
  input  logic [6:0] data_in_2,
  input  logic [6:0] data_in_3,
  output logic       in_ready_1,
  output logic       in_ready_2,
  output logic       in_ready_3,
  input  logic       ready_slave1,
  input  logic       ready_slave2,
  output logic       valid_slave1,
  output logic       valid_slave2,
  output logic [2:0] addr_out,
  output logic [2:0] value_out,
  output logic       handshake_slave1,
  output logic       handshake_slave2,
  output logic [1:0] grant_id,
  output logic       timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [6:0] mem [3][DEPTH];
  logic [AW-1:0] wptr [3];
  logic [AW-1:0] rptr [3];
  logic [AW:0] count [3];
  logic [6:0] din [3];
  logic [6:0] head [3];
  logic [6:0] hp;
  logic [2:0] in_valid, rdy, push, pop;
  logic [3:0] ne;
  logic [1:0] last_grant, o0, o1, pick;
  logic [CNT_W-1:0] cnt;
  logic hs, done;
  assign in_valid = {in_valid_3, in_valid_2, in_valid_1};
  assign din = '{data_in_1, data_in_2, data_in_3};
  assign {in_ready_3, in_ready_2, in_ready_1} = rdy;
  assign hs = (valid_slave1 && ready_slave1) || (valid_slave2 && ready_slave2);
  assign done = hs || cnt == LAST;
  always_comb begin
    rdy = '0;
    push = '0;
    pop = '0;
    ne = '0;
    for (int i = 0; i < 3; i++) begin
      rdy[i] = count[i] != FULL;
      push[i] = in_valid[i] && rdy[i];
      pop[i] = state == SEND && grant_id == 2'(i + 1) && done;
      head[i] = mem[i][rptr[i]];
      ne[i+1] = count[i] != '0;
    end
  end
  // Search order starts just after the last master served, wrapping 3 -> 1
  always_comb begin
    o0 = last_grant == 2'd1 ? 2'd2 : last_grant == 2'd2 ? 2'd3 : 2'd1;
    o1 = last_grant == 2'd1 ? 2'd3 : last_grant == 2'd2 ? 2'd1 : 2'd2;
    pick = ne[o0] ? o0 : ne[o1] ? o1 : ne[last_grant] ? last_grant : 2'd0;
    hp = pick == 2'd1 ? head[0] : pick == 2'd2 ? head[1] : head[2];
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (push[i]) mem[i][wptr[i]] <= din[i];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        count[i] <= '0;
      end else begin
        wptr[i] <= wptr[i] + AW'(push[i]);
        rptr[i] <= rptr[i] + AW'(pop[i]);
        count[i] <= count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 2'd3;
      cnt <= '0;
      grant_id <= '0;
      addr_out <= '0;
      value_out <= '0;
      valid_slave1 <= 1'b0;
      valid_slave2 <= 1'b0;
      handshake_slave1 <= 1'b0;
      handshake_slave2 <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      handshake_slave1 <= 1'b0;
      handshake_slave2 <= 1'b0;
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (pick != 2'd0) begin
          grant_id <= pick;
          addr_out <= hp[5:3];
          value_out <= hp[2:0];
          valid_slave1 <= ~hp[6];
          valid_slave2 <= hp[6];
          cnt <= '0;
          state <= SEND;
        end
      end else if (done) begin
        handshake_slave1 <= valid_slave1 && ready_slave1;
        handshake_slave2 <= valid_slave2 && ready_slave2;
        timeout_err <= ~hs;
        grant_id <= '0;
        addr_out <= '0;
        value_out <= '0;
        valid_slave1 <= 1'b0;
        valid_slave2 <= 1'b0;
        last_grant <= grant_id;
        state <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
